pkt_fragmenter: RTL and testbench
=================================

Name: pkt_fragmenter

Overview:
- Consumer of the send controller's `start_frag_pkt` / `frag_pkt_done` handshake.
- Latches one encapsulated packet produced by the encapsulation stage and splits it into NUMBER_FRAG fixed-width fragments.
- Emits fragments one at a time over a valid/ready lane interface toward the router output lane. Each fragment carries index, last flag and routing header.
- Pulses `frag_pkt_done` once the last fragment is accepted, so the send controller can return to IDLE.

Parameters:
- DFX_WIDTH, 2, width of source/destination DFX (router) id.
- SEQ_NUM_WIDTH, 1, width of the sequence number.
- NUMBER_FRAG, 5, fragments per packet (must be >= 2).
- FRAG_DATA_WIDTH, 32, payload bits per fragment.
- IDX_WIDTH, 3, fragment index width; must satisfy 2^IDX_WIDTH >= NUMBER_FRAG.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_frag_pkt  in  1  level request from send controller; held high while it waits for done
- pkt_data  in  NUMBER_FRAG*FRAG_DATA_WIDTH  encapsulated packet from the encap stage
- pkt_src_dfx  in  DFX_WIDTH  source router id
- pkt_dst_dfx  in  DFX_WIDTH  destination router id
- pkt_sn  in  SEQ_NUM_WIDTH  sequence number
- frag_pkt_done  out  1  one-cycle pulse when the packet is fully sent
- frag_valid  out  1  fragment valid
- frag_ready  in  1  lane accepts the fragment
- frag_data  out  FRAG_DATA_WIDTH  fragment payload
- frag_idx  out  IDX_WIDTH  fragment index, 0..NUMBER_FRAG-1
- frag_last  out  1  high on index NUMBER_FRAG-1
- frag_src_dfx  out  DFX_WIDTH  latched source id
- frag_dst_dfx  out  DFX_WIDTH  latched destination id
- frag_sn  out  SEQ_NUM_WIDTH  latched sequence number
- busy  out  1  high in SEND or DONE

Behaviour:
- Reset: one clock, synchronous active-high `rst`. All outputs and internal registers reset to 0, state goes to IDLE, `start_prev` goes to 0. Reset asserted mid-packet aborts it; no done pulse is generated.
- Trigger: registered edge detect, `start_edge = start_frag_pkt && !start_prev`; `start_prev` samples `start_frag_pkt` every cycle. A level held high never re-triggers. Edges seen outside IDLE are ignored and not queued.
- IDLE:
  - Outputs `frag_valid=0`, `busy=0`.
  - On `start_edge`, latch `pkt_data`, `pkt_src_dfx`, `pkt_dst_dfx`, `pkt_sn` into holding registers, clear `frag_cnt` to 0, go to SEND.
- SEND:
  - `frag_valid=1`.
  - `frag_data = pkt_reg[frag_cnt*FRAG_DATA_WIDTH +: FRAG_DATA_WIDTH]`, so fragment 0 is the LSB slice.
  - `frag_idx = frag_cnt`; `frag_last = (frag_cnt == NUMBER_FRAG-1)`; header outputs come from the latched copies.
  - On `frag_valid && frag_ready`: if `frag_last`, go to DONE; otherwise increment `frag_cnt`.
  - No handshake leaves all outputs unchanged. Data, index and header must be stable while valid is high and ready is low.
- DONE: `frag_valid=0`, `frag_pkt_done=1` for exactly this one cycle, then IDLE.
- `frag_pkt_done` is 0 in every other state.
- Latency:
  - Edge sampled in cycle N gives `frag_valid=1` in cycle N+1.
  - With `frag_ready` tied high, fragment k is accepted in cycle N+1+k.
  - Done pulse in cycle N+1+NUMBER_FRAG; IDLE in cycle N+2+NUMBER_FRAG.
- `frag_cnt` never exceeds NUMBER_FRAG-1 and never wraps; unused index codes are unreachable.
- Inputs `pkt_*` changing after the latch cycle do not affect the fragments in flight.
- Back-to-back packets: the send controller drops `start_frag_pkt` after seeing done. The next rising edge, which needs at least one low cycle, starts a new packet from IDLE.
- An illegal state encoding recovers to IDLE with outputs 0.
- The output interface is fully registered; there is no combinational path from `frag_ready` to `frag_valid`.

Decomposition:
- Shared package holds the state encodings (IDLE/SEND/DONE) and the DFX/SEQ_NUM widths also used by the send controller, encap stage and receive controller.
- No sub-module is needed. The edge detector is a single flop and stays inline.

Test Plan:
- Basic send, NUMBER_FRAG=5, W=32, `pkt_data` words 0x11111111..0x55555555 (fragment 0 = 0x11111111), src=1, dst=2, sn=1, `frag_ready`=1 → idx 0..4 on consecutive cycles carry 0x11111111..0x55555555; `frag_last` only on idx 4; `frag_pkt_done` pulses once, 6 cycles after the edge.
- Backpressure: `frag_ready` low for 3 cycles during idx 2 → valid stays high with data 0x33333333 and idx 2 stable; completion delayed by exactly 3 cycles.
- Held level: `start_frag_pkt` stays high for 20 cycles → exactly one packet (5 fragments) and one done pulse.
- Back-to-back: start drops for 1 cycle after done, rises again with dst=3, sn=0 → second packet carries `frag_dst_dfx=3`, `frag_sn=0`, and no stale data from packet one.
- Input change mid-send: `pkt_data` and `pkt_dst_dfx` altered after the latch → emitted fragments still match the latched values.
- Reset mid-packet: `rst`=1 for one cycle during idx 3 → next cycle `frag_valid=0`, `busy=0`, no done pulse; a new edge afterwards restarts from idx 0.

Source files
------------

// File: rtl/pkt_fragmenter_pkg.sv
// Shared definitions for the packet send path: router id / sequence number widths
// and the fragmenter state encoding.
package pkt_fragmenter_pkg;

  localparam int PKT_DFX_WIDTH       = 2;
  localparam int PKT_SEQ_NUM_WIDTH   = 1;
  localparam int PKT_NUMBER_FRAG     = 5;
  localparam int PKT_FRAG_DATA_WIDTH = 32;
  localparam int PKT_IDX_WIDTH       = 3;

  typedef enum logic [1:0] {
    FRAG_IDLE = 2'd0,
    FRAG_SEND = 2'd1,
    FRAG_DONE = 2'd2
  } fragState_e;

endpackage

// File: rtl/pkt_fragmenter_if.sv
// Fragment lane between the fragmenter (master) and the router output lane (slave).
interface pkt_fragmenter_if
  import pkt_fragmenter_pkg::*;
#(
  parameter int DFX_WIDTH       = PKT_DFX_WIDTH,
  parameter int SEQ_NUM_WIDTH   = PKT_SEQ_NUM_WIDTH,
  parameter int FRAG_DATA_WIDTH = PKT_FRAG_DATA_WIDTH,
  parameter int IDX_WIDTH       = PKT_IDX_WIDTH
);

  logic                       frag_valid;
  logic                       frag_ready;
  logic [FRAG_DATA_WIDTH-1:0] frag_data;
  logic [IDX_WIDTH-1:0]       frag_idx;
  logic                       frag_last;
  logic [DFX_WIDTH-1:0]       frag_src_dfx;
  logic [DFX_WIDTH-1:0]       frag_dst_dfx;
  logic [SEQ_NUM_WIDTH-1:0]   frag_sn;

  modport master (
    output frag_valid, frag_data, frag_idx, frag_last,
           frag_src_dfx, frag_dst_dfx, frag_sn,
    input  frag_ready
  );

  modport slave (
    input  frag_valid, frag_data, frag_idx, frag_last,
           frag_src_dfx, frag_dst_dfx, frag_sn,
    output frag_ready
  );

endinterface

// File: rtl/pkt_fragmenter.sv
// Latches one encapsulated packet on a rising start request and streams it out as
// NUMBER_FRAG fragments, then pulses frag_pkt_done_o back to the send controller.
module pkt_fragmenter
  import pkt_fragmenter_pkg::*;
#(
  parameter int DFX_WIDTH       = PKT_DFX_WIDTH,
  parameter int SEQ_NUM_WIDTH   = PKT_SEQ_NUM_WIDTH,
  parameter int NUMBER_FRAG     = PKT_NUMBER_FRAG,
  parameter int FRAG_DATA_WIDTH = PKT_FRAG_DATA_WIDTH,
  parameter int IDX_WIDTH       = PKT_IDX_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_frag_pkt_i,
  input  logic [NUMBER_FRAG*FRAG_DATA_WIDTH-1:0] pkt_data_i,
  input  logic [DFX_WIDTH-1:0]                   pkt_src_dfx_i,
  input  logic [DFX_WIDTH-1:0]                   pkt_dst_dfx_i,
  input  logic [SEQ_NUM_WIDTH-1:0]               pkt_sn_i,
  output logic                                   frag_pkt_done_o,
  output logic                                   busy_o,
  pkt_fragmenter_if.master                       frag_o
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUMBER_FRAG - 1);

  fragState_e                           state_q, state_d;
  logic                                 startPrev_q;
  logic [IDX_WIDTH-1:0]                 fragCnt_q, fragCnt_d;
  logic [NUMBER_FRAG*FRAG_DATA_WIDTH-1:0] pktReg_q, pktReg_d;
  logic [DFX_WIDTH-1:0]                 srcDfx_q, srcDfx_d;
  logic [DFX_WIDTH-1:0]                 dstDfx_q, dstDfx_d;
  logic [SEQ_NUM_WIDTH-1:0]             sn_q, sn_d;

  logic                       startEdge;
  logic                       sendValid;
  logic                       doneOut;
  logic                       busyOut;
  logic                       lastFrag;
  logic [FRAG_DATA_WIDTH-1:0] fragWord;

  assign startEdge = start_frag_pkt_i && !startPrev_q;
  assign lastFrag  = (fragCnt_q == LAST_IDX);
  assign fragWord  = pktReg_q[int'(fragCnt_q)*FRAG_DATA_WIDTH +: FRAG_DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    fragCnt_d = fragCnt_q;
    pktReg_d  = pktReg_q;
    srcDfx_d  = srcDfx_q;
    dstDfx_d  = dstDfx_q;
    sn_d      = sn_q;
    sendValid = 1'b0;
    doneOut   = 1'b0;
    busyOut   = 1'b0;
    case (state_q)
      FRAG_IDLE: begin
        if (startEdge) begin
          pktReg_d  = pkt_data_i;
          srcDfx_d  = pkt_src_dfx_i;
          dstDfx_d  = pkt_dst_dfx_i;
          sn_d      = pkt_sn_i;
          fragCnt_d = '0;
          state_d   = FRAG_SEND;
        end
      end
      FRAG_SEND: begin
        sendValid = 1'b1;
        busyOut   = 1'b1;
        if (frag_o.frag_ready) begin
          if (lastFrag) state_d = FRAG_DONE;
          else          fragCnt_d = fragCnt_q + IDX_WIDTH'(1);
        end
      end
      FRAG_DONE: begin
        doneOut = 1'b1;
        busyOut = 1'b1;
        state_d = FRAG_IDLE;
      end
      default: begin
        state_d   = FRAG_IDLE;
        fragCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FRAG_IDLE;
      startPrev_q <= 1'b0;
      fragCnt_q   <= '0;
      pktReg_q    <= '0;
      srcDfx_q    <= '0;
      dstDfx_q    <= '0;
      sn_q        <= '0;
    end else begin
      state_q     <= state_d;
      startPrev_q <= start_frag_pkt_i;
      fragCnt_q   <= fragCnt_d;
      pktReg_q    <= pktReg_d;
      srcDfx_q    <= srcDfx_d;
      dstDfx_q    <= dstDfx_d;
      sn_q        <= sn_d;
    end
  end

  // Lane outputs decode only from registers, so frag_ready never reaches frag_valid.
  assign frag_o.frag_valid   = sendValid;
  assign frag_o.frag_data    = sendValid ? fragWord : '0;
  assign frag_o.frag_idx     = sendValid ? fragCnt_q : '0;
  assign frag_o.frag_last    = sendValid && lastFrag;
  assign frag_o.frag_src_dfx = srcDfx_q;
  assign frag_o.frag_dst_dfx = dstDfx_q;
  assign frag_o.frag_sn      = sn_q;
  assign frag_pkt_done_o     = doneOut;
  assign busy_o              = busyOut;

endmodule

// File: tb/tb_pkt_fragmenter.sv
// Bench for pkt_fragmenter: directed and randomized packets compared against a
// fragment list and latency timeline derived from the packet itself.
module tb_pkt_fragmenter;
  import pkt_fragmenter_pkg::*;

  localparam int NF = 5;
  localparam int FW = 32;
  localparam int IW = 3;
  localparam int DW = 2;
  localparam int SW = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NF*FW-1:0]  pktData;
  logic [DW-1:0]     srcDfx;
  logic [DW-1:0]     dstDfx;
  logic [SW-1:0]     seqNum;
  logic              done;
  logic              busy;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  pkt_fragmenter_if #(
    .DFX_WIDTH(DW), .SEQ_NUM_WIDTH(SW), .FRAG_DATA_WIDTH(FW), .IDX_WIDTH(IW)
  ) fragIf ();

  pkt_fragmenter #(
    .DFX_WIDTH(DW), .SEQ_NUM_WIDTH(SW), .NUMBER_FRAG(NF),
    .FRAG_DATA_WIDTH(FW), .IDX_WIDTH(IW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_frag_pkt_i (start),
    .pkt_data_i       (pktData),
    .pkt_src_dfx_i    (srcDfx),
    .pkt_dst_dfx_i    (dstDfx),
    .pkt_sn_i         (seqNum),
    .frag_pkt_done_o  (done),
    .busy_o           (busy),
    .frag_o           (fragIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one packet and checks every cycle against the expected fragment list and
  // the edge->valid->done timeline; stalls ready for stallLen cycles on fragment stallAt.
  task automatic applyStimulus(input logic [NF*FW-1:0] pkt, input logic [DW-1:0] s,
                               input logic [DW-1:0] d, input logic [SW-1:0] q,
                               input int stallAt, input int stallLen,
                               input int holdCycles, input bit scramble);
    logic [FW-1:0] expWords [NF];
    int accepted  = 0;
    int stallLeft = stallLen;
    int expDone   = NF + stallLen + 1;
    int window    = NF + stallLen + 2;
    for (int k = 0; k < NF; k++) expWords[k] = FW'(pkt >> (k * FW));
    if (holdCycles + 2 > window) window = holdCycles + 2;
    pktData = pkt;
    srcDfx  = s;
    dstDfx  = d;
    seqNum  = q;
    start   = 1'b1;
    fragIf.frag_ready = 1'b1;
    for (int cycle = 1; cycle <= window; cycle++) begin
      @(negedge clk);
      if (scramble && cycle == 1) begin
        pktData = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        srcDfx  = ~s;
        dstDfx  = ~d;
        seqNum  = ~q;
      end
      checkOutput("valid", fragIf.frag_valid, (cycle <= NF + stallLen));
      checkOutput("done", done, (cycle == expDone));
      checkOutput("busy", busy, (cycle <= expDone));
      if (fragIf.frag_valid && accepted < NF) begin
        checkOutput("data", fragIf.frag_data, expWords[accepted]);
        checkOutput("idx", fragIf.frag_idx, accepted);
        checkOutput("last", fragIf.frag_last, (accepted == NF - 1));
        checkOutput("src", fragIf.frag_src_dfx, s);
        checkOutput("dst", fragIf.frag_dst_dfx, d);
        checkOutput("sn", fragIf.frag_sn, q);
      end
      if (accepted == stallAt && stallLeft > 0) begin
        fragIf.frag_ready = 1'b0;
        stallLeft--;
      end else begin
        fragIf.frag_ready = 1'b1;
      end
      if (fragIf.frag_valid && fragIf.frag_ready) accepted++;
      if (cycle >= expDone && cycle >= holdCycles) start = 1'b0;
    end
    checkOutput("frag_count", accepted, NF);
    start = 1'b0;
  endtask

  initial begin
    logic [NF*FW-1:0] rndPkt;
    rst = 1'b1;
    start = 1'b0;
    pktData = '0;
    srcDfx = '0;
    dstDfx = '0;
    seqNum = '0;
    fragIf.frag_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", fragIf.frag_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data", fragIf.frag_data, 0);
    checkOutput("rst_idx", fragIf.frag_idx, 0);
    checkOutput("rst_last", fragIf.frag_last, 0);
    checkOutput("rst_hdr", {fragIf.frag_src_dfx, fragIf.frag_dst_dfx, fragIf.frag_sn}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_valid", fragIf.frag_valid, 0);

    $display("[TB] basic send");
    applyStimulus({32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                  2'd1, 2'd2, 1'b1, -1, 0, 0, 1'b0);
    $display("[TB] back-to-back packet");
    applyStimulus({32'hA5A5A5A5, 32'h0F0F0F0F, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678},
                  2'd1, 2'd3, 1'b0, -1, 0, 0, 1'b0);
    @(negedge clk);
    $display("[TB] backpressure on fragment 2");
    applyStimulus({32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                  2'd1, 2'd2, 1'b1, 2, 3, 0, 1'b0);
    @(negedge clk);
    $display("[TB] start held high");
    applyStimulus({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                  2'd2, 2'd1, 1'b0, -1, 0, 20, 1'b0);
    @(negedge clk);
    $display("[TB] inputs change after latch");
    applyStimulus({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                  2'd0, 2'd3, 1'b1, 1, 2, 0, 1'b1);

    $display("[TB] randomized packets");
    for (int p = 0; p < 6; p++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rndPkt = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(rndPkt, DW'($urandom()), DW'($urandom()), SW'($urandom()),
                    int'($urandom_range(0, NF - 1)), int'($urandom_range(0, 4)),
                    0, 1'($urandom()));
    end

    $display("[TB] reset mid-packet");
    @(negedge clk);
    pktData = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    start = 1'b1;
    fragIf.frag_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_idx", fragIf.frag_idx, 3);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post_rst_valid", fragIf.frag_valid, 0);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_done", done, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("aborted_done", done, 0);
      checkOutput("aborted_valid", fragIf.frag_valid, 0);
    end
    applyStimulus({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                  2'd3, 2'd0, 1'b1, -1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
